// File: rtl/gpr_pkg.sv
// Shared defaults and types for the general-purpose register file.
// Optional feature macro used by gpr_file_sb: GPR_BYPASS_EN (write-through bypass).
package gpr_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Register index that is hardwired to zero.
  localparam int ZERO_REG  = 0;

  typedef logic [$clog2(NREGS_DEF)-1:0] gpr_addr_t;
  typedef logic [XLEN_DEF-1:0]          gpr_data_t;

endpackage : gpr_pkg

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// count of busy registers. Priority per register is flush > alloc > write.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc,
  input  logic [AW-1:0]    alloc_addr,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [CW-1:0]    pending_cnt
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic             alloc_valid;
  logic             write_valid;
  logic             cnt_inc;
  logic             cnt_dec;

  assign alloc_valid = alloc && (alloc_addr != AW'(ZERO_REG));
  assign write_valid = we && (wa != AW'(ZERO_REG));

  // Per-register next busy state; register 0 can never become busy.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == ZERO_REG) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = flush                                ? 1'b0 :
                               (alloc_valid && alloc_addr == AW'(gi)) ? 1'b1 :
                               (write_valid && wa == AW'(gi))         ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  // Counter moves only on busy-bit transitions so it always equals popcount(busy).
  always_comb begin
    cnt_inc  = alloc_valid && !busy_reg[alloc_addr];
    // A write whose target is re-allocated in the same cycle does not clear it.
    cnt_dec  = write_valid && busy_reg[wa] && !(alloc_valid && alloc_addr == wa);
    cnt_next = cnt_reg;
    if (flush) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

  // Scoreboard state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy        = busy_reg;
  assign pending_cnt = cnt_reg;

endmodule : gpr_scoreboard

// File: rtl/gpr_file_sb.sv
// Parametrised two-read/one-write register file with a pending-write
// scoreboard for RAW hazard detection in decode.
// Optional feature macro: GPR_BYPASS_EN adds a write-through bypass on
// both read ports (same-cycle write data visible, busy suppressed).
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            alloc,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            flush,
  output logic [CW-1:0]   pending_cnt
);

  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [NREGS-1:0] busy;

  gpr_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .CW    (CW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc       (alloc),
    .alloc_addr  (alloc_addr),
    .we          (we),
    .wa          (wa),
    .flush       (flush),
    .busy        (busy),
    .pending_cnt (pending_cnt)
  );

  // Storage is flops, not RAM, because every entry clears asynchronously on reset.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_regs
      if (gi == ZERO_REG) begin : g_zero
        // Register 0 never loads, so it stays at its reset value of zero.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            regs_reg[gi] <= '0;
          end else begin
            regs_reg[gi] <= '0;
          end
        end
      end else begin : g_reg
        // Writeback commit to this register; flush does not block it.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            regs_reg[gi] <= '0;
          end else if (we && wa == AW'(gi)) begin
            regs_reg[gi] <= wd;
          end
        end
      end
    end
  endgenerate

`ifdef GPR_BYPASS_EN
  logic byp1;
  logic byp2;

  // Combinational read ports with same-cycle writeback forwarding.
  always_comb begin
    byp1     = we && (wa != AW'(ZERO_REG)) && (wa == ra1);
    byp2     = we && (wa != AW'(ZERO_REG)) && (wa == ra2);
    rd1      = byp1 ? wd : regs_reg[ra1];
    rd2      = byp2 ? wd : regs_reg[ra2];
    rs1_busy = busy[ra1] && !byp1;
    rs2_busy = busy[ra2] && !byp2;
  end
`else
  // Combinational read ports from stored state only; a same-cycle write shows next cycle.
  always_comb begin
    rd1      = regs_reg[ra1];
    rd2      = regs_reg[ra2];
    rs1_busy = busy[ra1];
    rs2_busy = busy[ra2];
  end
`endif

endmodule : gpr_file_sb

// File: tb/tb_gpr_file_sb.sv
// Directed self-checking bench for gpr_file_sb (default 32x32 configuration).
module tb_gpr_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, alloc_addr;
  logic [31:0] rd1, rd2, wd;
  logic        rs1_busy, rs2_busy, we, alloc, flush;
  logic [5:0]  pending_cnt;

  int checks = 0;
  int errors = 0;

  gpr_file_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .alloc       (alloc),
    .alloc_addr  (alloc_addr),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("ok   %-18s obs=%h exp=%h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and drop all one-shot controls.
  task automatic tick();
    @(posedge clk);
    #1;
    we = 1'b0; alloc = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; alloc = 1'b0; flush = 1'b0;
    ra1 = 5'd5; ra2 = 5'd0; wa = '0; wd = '0; alloc_addr = '0;
    #2;
    check("rst_rd1", rd1, 32'h0);
    check("rst_busy1", {31'b0, rs1_busy}, 32'h0);
    check("rst_cnt", {26'b0, pending_cnt}, 32'h0);
    #10 rst_n = 1'b1;

    // Write x5 while allocating it: alloc wins, so x5 commits and is busy.
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; alloc = 1'b1; alloc_addr = 5'd5;
    tick();
    check("wr_x5", rd1, 32'hDEADBEEF);
    check("busy_x5", {31'b0, rs1_busy}, 32'h1);
    check("cnt_x5", {26'b0, pending_cnt}, 32'h1);
    // Asynchronous reset between edges.
    rst_n = 1'b0; #1;
    check("arst_rd1", rd1, 32'h0);
    check("arst_busy1", {31'b0, rs1_busy}, 32'h0);
    check("arst_cnt", {26'b0, pending_cnt}, 32'h0);
    rst_n = 1'b1;

    // Register 0: write and alloc both dropped.
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; alloc = 1'b1; alloc_addr = 5'd0; ra1 = 5'd0;
    tick();
    check("x0_rd1", rd1, 32'h0);
    check("x0_busy1", {31'b0, rs1_busy}, 32'h0);
    check("x0_cnt", {26'b0, pending_cnt}, 32'h0);

    // Basic hazard on x7.
    alloc = 1'b1; alloc_addr = 5'd7; ra2 = 5'd7;
    tick();
    check("hz_busy2", {31'b0, rs2_busy}, 32'h1);
    check("hz_cnt1", {26'b0, pending_cnt}, 32'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h1234;
    tick();
    check("hz_rd2", rd2, 32'h1234);
    check("hz_clr2", {31'b0, rs2_busy}, 32'h0);
    check("hz_cnt0", {26'b0, pending_cnt}, 32'h0);

    // Build up x3 and x9 busy.
    alloc = 1'b1; alloc_addr = 5'd3;
    tick();
    alloc = 1'b1; alloc_addr = 5'd9;
    tick();
    check("cnt_2", {26'b0, pending_cnt}, 32'h2);
    // Alloc + write of busy x3: stays busy, count unchanged, data commits.
    alloc = 1'b1; alloc_addr = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h33; ra1 = 5'd3;
    tick();
    check("aw_busy3", {31'b0, rs1_busy}, 32'h1);
    check("aw_rd3", rd1, 32'h33);
    check("aw_cnt", {26'b0, pending_cnt}, 32'h2);
    // Write x9 and alloc x4 together: -1 +1.
    we = 1'b1; wa = 5'd9; wd = 32'h99; alloc = 1'b1; alloc_addr = 5'd4;
    ra1 = 5'd9; ra2 = 5'd4;
    tick();
    check("net_busy9", {31'b0, rs1_busy}, 32'h0);
    check("net_rd9", rd1, 32'h99);
    check("net_busy4", {31'b0, rs2_busy}, 32'h1);
    check("net_cnt", {26'b0, pending_cnt}, 32'h2);
    // Alloc of an already-busy register does not count twice.
    alloc = 1'b1; alloc_addr = 5'd4;
    tick();
    check("rebusy_cnt", {26'b0, pending_cnt}, 32'h2);

    // Flush, then x1..x3 busy, then flush with a write of x2.
    flush = 1'b1;
    tick();
    check("fl_cnt0", {26'b0, pending_cnt}, 32'h0);
    check("fl_busy4", {31'b0, rs2_busy}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      alloc = 1'b1; alloc_addr = 5'(i);
      tick();
    end
    check("fl_cnt3", {26'b0, pending_cnt}, 32'h3);
    flush = 1'b1; we = 1'b1; wa = 5'd2; wd = 32'h55; ra1 = 5'd2; ra2 = 5'd1;
    tick();
    check("fl_cnt", {26'b0, pending_cnt}, 32'h0);
    check("fl_rd2", rd1, 32'h55);
    check("fl_busy2", {31'b0, rs1_busy}, 32'h0);
    check("fl_busy1", {31'b0, rs2_busy}, 32'h0);

    // Bypass behaviour on x10 (busy, never written before).
    alloc = 1'b1; alloc_addr = 5'd10;
    tick();
    ra1 = 5'd10; we = 1'b1; wa = 5'd10; wd = 32'hA5A5A5A5;
    #1;
`ifdef GPR_BYPASS_EN
    check("byp_rd1", rd1, 32'hA5A5A5A5);
    check("byp_busy1", {31'b0, rs1_busy}, 32'h0);
`else
    check("nobyp_rd1", rd1, 32'h0);
    check("nobyp_busy1", {31'b0, rs1_busy}, 32'h1);
`endif
    tick();
    check("byp_next_rd1", rd1, 32'hA5A5A5A5);
    check("byp_next_busy", {31'b0, rs1_busy}, 32'h0);
    check("byp_next_cnt", {26'b0, pending_cnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gpr_file_sb
